// File: rtl/aes_stream_loader.sv
// AES stream loader: gathers key and text words from an upstream stream, starts AES_TOP,
// captures its encryption and decryption results and streams them downstream.
module aes_stream_loader #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_cfg_mode,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [31:0]  i_in_data,
  output logic [255:0] o_aes_key,
  output logic [127:0] o_aes_intxt,
  output logic [3:0]   o_aes_nk,
  output logic [3:0]   o_aes_nr,
  output logic         o_aes_keyvalid,
  input  logic [127:0] i_aes_outtxt,
  input  logic         i_aes_enc_finish,
  input  logic         i_aes_dec_finish,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [31:0]  o_out_data,
  output logic         o_out_last,
  output logic         o_out_is_dec,
  output logic         o_busy,
  output logic         o_err
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoadKey, StLoadTxt, StStart, StWait, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_mode;
  logic [255:0]    r_key;
  logic [127:0]    r_txt;
  logic [2:0]      r_widx;
  logic            r_enc_flag, r_dec_flag;
  logic [127:0]    r_enc_buf, r_dec_buf;
  logic            r_enc_full, r_dec_full;
  logic            r_enc_seen, r_dec_seen;
  logic [1:0]      r_oidx;
  logic            r_osel;
  logic [CntW-1:0] r_tcnt;

  logic            w_xfer, w_active, w_enc_evt, w_dec_evt, w_timeout, w_cur_full, w_ohs;
  logic [2:0]      w_nk_m1;
  logic [127:0]    w_cur_buf;

  // Key-size decode from the latched mode; reserved mode behaves as AES-128.
  always_comb begin
    o_aes_nk = 4'd4;
    o_aes_nr = 4'd10;
    w_nk_m1  = 3'd3;
    unique case (r_mode)
      2'b01: begin o_aes_nk = 4'd6; o_aes_nr = 4'd12; w_nk_m1 = 3'd5; end
      2'b10: begin o_aes_nk = 4'd8; o_aes_nr = 4'd14; w_nk_m1 = 3'd7; end
      default: ;
    endcase
  end

  assign o_in_ready = !i_rst && (r_state == StIdle || r_state == StLoadKey ||
                                 r_state == StLoadTxt);
  assign w_xfer     = i_in_valid && o_in_ready;
  assign w_active   = (r_state == StWait) || (r_state == StDrain);
  // Finish flags are levels; only their rising edge counts, and only after START.
  assign w_enc_evt  = w_active && i_aes_enc_finish && !r_enc_flag;
  assign w_dec_evt  = w_active && i_aes_dec_finish && !r_dec_flag;
  assign w_timeout  = w_active && (!r_enc_seen || !r_dec_seen) && !w_enc_evt && !w_dec_evt &&
                      (r_tcnt == CntW'(TIMEOUT - 1));

  assign w_cur_full   = r_osel ? r_dec_full : r_enc_full;
  assign w_cur_buf    = r_osel ? r_dec_buf : r_enc_buf;
  assign o_out_valid  = (r_state == StDrain) && w_cur_full;
  assign w_ohs        = o_out_valid && i_out_ready;
  assign o_out_data   = o_out_valid ? w_cur_buf[7'd127 - {r_oidx, 5'd0} -: 32] : 32'd0;
  assign o_out_last   = o_out_valid && (r_oidx == 2'd3);
  assign o_out_is_dec = o_out_valid && r_osel;

  assign o_aes_key      = r_key;
  assign o_aes_intxt    = r_txt;
  assign o_aes_keyvalid = (r_state == StStart);
  assign o_busy         = (r_state != StIdle);
  assign o_err          = w_timeout;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic; a timeout aborts from any waiting state.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_xfer) w_state_d = StLoadKey;
      StLoadKey: if (w_xfer && r_widx == w_nk_m1) w_state_d = StLoadTxt;
      StLoadTxt: if (w_xfer && r_widx == 3'd3) w_state_d = StStart;
      StStart:   w_state_d = StWait;
      StWait:    if (r_enc_full) w_state_d = StDrain;
      StDrain:   if (w_ohs && r_osel && r_oidx == 2'd3) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
    if (w_timeout) w_state_d = StIdle;
  end

  // Word loading, finish capture, drain sequencing and timeout counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode     <= 2'b00;
      r_key      <= '0;
      r_txt      <= '0;
      r_widx     <= '0;
      r_enc_flag <= 1'b0;
      r_dec_flag <= 1'b0;
      r_enc_buf  <= '0;
      r_dec_buf  <= '0;
      r_enc_full <= 1'b0;
      r_dec_full <= 1'b0;
      r_enc_seen <= 1'b0;
      r_dec_seen <= 1'b0;
      r_oidx     <= '0;
      r_osel     <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      r_enc_flag <= i_aes_enc_finish;
      r_dec_flag <= i_aes_dec_finish;

      if (w_xfer) begin
        if (r_state == StIdle) begin
          // Clearing the whole key keeps the unused tail zero for shorter keys.
          r_mode <= i_cfg_mode;
          r_key  <= {i_in_data, 224'd0};
          r_txt  <= '0;
          r_widx <= 3'd1;
        end else if (r_state == StLoadKey) begin
          r_key[8'd255 - {r_widx, 5'd0} -: 32] <= i_in_data;
          r_widx <= (r_widx == w_nk_m1) ? 3'd0 : r_widx + 3'd1;
        end else begin
          r_txt[7'd127 - {r_widx[1:0], 5'd0} -: 32] <= i_in_data;
          r_widx <= (r_widx == 3'd3) ? 3'd0 : r_widx + 3'd1;
        end
      end

      if (r_state == StStart) begin
        r_tcnt     <= '0;
        r_enc_seen <= 1'b0;
        r_dec_seen <= 1'b0;
        r_oidx     <= '0;
        r_osel     <= 1'b0;
      end else if (w_active) begin
        r_tcnt <= (w_enc_evt || w_dec_evt) ? '0 : r_tcnt + CntW'(1);
      end

      if (w_ohs) begin
        r_oidx <= r_oidx + 2'd1;
        if (r_oidx == 2'd3) begin
          if (r_osel) begin
            r_dec_full <= 1'b0;
            r_osel     <= 1'b0;
          end else begin
            r_enc_full <= 1'b0;
            r_osel     <= 1'b1;
          end
        end
      end

      if (w_enc_evt) begin
        r_enc_buf  <= i_aes_outtxt;
        r_enc_full <= 1'b1;
        r_enc_seen <= 1'b1;
      end
      if (w_dec_evt) begin
        r_dec_buf  <= i_aes_outtxt;
        r_dec_full <= 1'b1;
        r_dec_seen <= 1'b1;
      end

      if (w_timeout) begin
        r_enc_buf  <= '0;
        r_dec_buf  <= '0;
        r_enc_full <= 1'b0;
        r_dec_full <= 1'b0;
        r_oidx     <= '0;
        r_osel     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Bench for aes_stream_loader: AES_TOP behavioural stand-in, word-queue scoreboard and
// per-cycle compare against the expected key/text, output words and timeout pulse.
module tb_aes_stream_loader;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cfg_mode;
  logic         in_valid, in_ready;
  logic [31:0]  in_data;
  logic [255:0] aes_key;
  logic [127:0] aes_intxt, aes_outtxt;
  logic [3:0]   aes_nk, aes_nr;
  logic         aes_keyvalid, aes_enc_finish, aes_dec_finish;
  logic         out_valid, out_ready, out_last, out_is_dec, busy, err;
  logic [31:0]  out_data;

  always #5 clk = ~clk;

  aes_stream_loader #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_mode(cfg_mode),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_aes_key(aes_key), .o_aes_intxt(aes_intxt), .o_aes_nk(aes_nk), .o_aes_nr(aes_nr),
    .o_aes_keyvalid(aes_keyvalid), .i_aes_outtxt(aes_outtxt),
    .i_aes_enc_finish(aes_enc_finish), .i_aes_dec_finish(aes_dec_finish),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .o_out_is_dec(out_is_dec), .o_busy(busy), .o_err(err)
  );

  int checks = 0;
  int failures = 0;

  // Model state
  logic [33:0]  exp_q[$];  // {is_dec, last, data}
  int           aes_t = -1;  // cycles since the start pulse, -1 when no transaction
  int           enc_d = 100, dec_d = 100, bp_mode = 0, kv_cnt = 0;
  bit           no_fin = 1'b0, g_to = 1'b0, err_seen = 1'b0;
  logic [127:0] g_ct = '0, g_pt = '0, exp_txt = '0, kv_txt = '0;
  logic [255:0] exp_key = '0, kv_key = '0;
  logic [3:0]   exp_nk = 4'd4, exp_nr = 4'd10, kv_nk = '0, kv_nr = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired, got no event expected event", name);
  endtask

  // Compare process: start pulse contents, every presented output word, timeout pulse.
  always @(negedge clk) begin
    if (rst) begin
      aes_t = -1;
      exp_q.delete();
    end else begin
      if (aes_keyvalid) begin
        kv_cnt++;
        aes_t  = 0;
        kv_key = aes_key;
        kv_txt = aes_intxt;
        kv_nk  = aes_nk;
        kv_nr  = aes_nr;
        check("aes_key", aes_key, exp_key);
        check("aes_intxt", aes_intxt, exp_txt);
        check("aes_nk", aes_nk, exp_nk);
        check("aes_nr", aes_nr, exp_nr);
      end else if (aes_t >= 0) begin
        aes_t++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else begin
          check("out_word", {out_is_dec, out_last, out_data}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      check("err", err, g_to && kv_cnt == 1 && aes_t == int'(TO));
      if (err) err_seen = 1'b1;
    end
  end

  // AES_TOP stand-in and downstream ready driver.
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    aes_enc_finish = (aes_t >= 0) && !no_fin && (aes_t >= enc_d);
    aes_dec_finish = (aes_t >= 0) && !no_fin && (aes_t >= dec_d);
    aes_outtxt     = (aes_t >= dec_d) ? g_pt : g_ct;
    case (bp_mode)
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send_word(input logic [31:0] w, input int gap);
    int  n;
    bit  ok;
    while ($urandom_range(99) < gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    cfg_mode = 2'($urandom);
    if (!ok) fail_now("in_ready_bound");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_out_is_dec"}, out_is_dec, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_keyvalid"}, aes_keyvalid, 1'b0);
    check({tag, "_key"}, aes_key, 256'd0);
    check({tag, "_intxt"}, aes_intxt, 128'd0);
    check({tag, "_nk"}, aes_nk, 4'd4);
    check({tag, "_nr"}, aes_nr, 4'd10);
  endtask

  task automatic run_txn(input logic [1:0] mode, input logic [255:0] key, input logic [127:0] txt,
                         input logic [127:0] ct, input int ed, input int dd, input int gap,
                         input int bp, input bit to, input bit rst_mid);
    int nk, n, hs;
    nk = (mode == 2'b01) ? 6 : (mode == 2'b10) ? 8 : 4;
    exp_key = key & ({256{1'b1}} << (256 - 32 * nk));
    exp_txt = txt;
    exp_nk  = 4'(nk);
    exp_nr  = 4'(nk + 6);
    kv_cnt  = 0;
    err_seen = 1'b0;
    g_ct = ct; g_pt = txt; enc_d = ed; dec_d = dd; no_fin = to; g_to = to; bp_mode = bp;
    if (!to) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, i == 3, ct[127 - 32 * i -: 32]});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, i == 3, txt[127 - 32 * i -: 32]});
    end
    cfg_mode = mode;
    for (int i = 0; i < nk; i++) send_word(key[255 - 32 * i -: 32], gap);
    for (int i = 0; i < 4; i++) send_word(txt[127 - 32 * i -: 32], gap);
    if (rst_mid) begin
      hs = 0;
      n = 0;
      while (hs < 2 && n < 200) begin
        @(negedge clk);
        if (out_valid && out_ready && !out_is_dec) hs++;
        n++;
      end
      if (hs < 2) fail_now("rst_mid_handshakes");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      check("rst_mid_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !busy) && n < 400);
    check("txn_busy_end", busy, 1'b0);
    check("txn_words_left", exp_q.size(), 0);
    check("keyvalid_pulses", kv_cnt, 1);
    check("err_pulse_seen", err_seen, to);
    @(posedge clk); #1;
  endtask

  logic [255:0] rk;
  logic [127:0] rt, rc;
  int           red;

  initial begin
    rst = 1'b1; cfg_mode = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    aes_enc_finish = 1'b0; aes_dec_finish = 1'b0; aes_outtxt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // AES-128 known vector
    run_txn(2'b00, 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
            128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            3, 6, 0, 0, 1'b0, 1'b0);
    check("pin128_key", kv_key,
          256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000);
    check("pin128_txt", kv_txt, 128'h00112233445566778899aabbccddeeff);
    check("pin128_nk", kv_nk, 4'd4);
    check("pin128_nr", kv_nr, 4'd10);

    // AES-192 known vector; key tail must stay zero
    run_txn(2'b01, 256'h000102030405060708090a0b0c0d0e0f1011121314151617_ffffffffffffffff,
            128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
            4, 5, 0, 0, 1'b0, 1'b0);
    check("pin192_key", kv_key,
          256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000);
    check("pin192_nk", kv_nk, 4'd6);
    check("pin192_nr", kv_nr, 4'd12);

    // AES-256 known vector with input gaps
    run_txn(2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089,
            5, 9, 40, 0, 1'b0, 1'b0);
    check("pin256_key", kv_key,
          256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("pin256_nk", kv_nk, 4'd8);
    check("pin256_nr", kv_nr, 4'd14);

    // Back-pressure 1-0-0-1 with decryption finishing during encryption drain
    run_txn(2'b00, 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
            128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            2, 5, 0, 1, 1'b0, 1'b0);

    // Timeout, then a normal transaction
    run_txn(2'b00, {8{32'h0badf00d}}, {4{32'h12345678}}, {4{32'hcafebabe}},
            100, 100, 0, 0, 1'b1, 1'b0);
    run_txn(2'b11, {8{32'h13572468}}, {4{32'h9abcdef0}}, {4{32'h0f1e2d3c}},
            3, 7, 10, 0, 1'b0, 1'b0);

    // Reset mid-drain after two encryption words, then a normal transaction
    run_txn(2'b01, {8{32'haaaa5555}}, {4{32'h11112222}}, {4{32'h33334444}},
            2, 4, 0, 0, 1'b0, 1'b1);
    run_txn(2'b10, {8{32'h01234567}}, {4{32'h89abcdef}}, {4{32'hdeadbeef}},
            4, 8, 0, 0, 1'b0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++) rk = {rk[223:0], 32'($urandom)};
      for (int i = 0; i < 4; i++) rt = {rt[95:0], 32'($urandom)};
      for (int i = 0; i < 4; i++) rc = {rc[95:0], 32'($urandom)};
      red = $urandom_range(2, 12);
      run_txn(2'($urandom_range(3)), rk, rt, rc, red, red + $urandom_range(1, 8), 30, 2,
              1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_stream_loader.md
AES_STREAM_LOADER -- requirements
Module: aes_stream_loader

Interface
REQ-001 Parameter TIMEOUT, default 1023: max cycles waited for each AES finish event before abort.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cfg_mode  in  2  key size: 00=AES-128, 01=AES-192, 10=AES-256, 11=reserved, treated as 00.
REQ-005 in_valid / in_ready / in_data  in / out / in  1 / 1 / 32  upstream word stream (key words, then 4 text words).
REQ-006 aes_key  out  256  key to AES_TOP; bits [0:31] = first key word; unused tail bits zero.
REQ-007 aes_intxt  out  128  input text to AES_TOP; bits [0:31] = first text word.
REQ-008 aes_nk / aes_nr  out  4 / 4  to AES_TOP: 4/10, 6/12 or 8/14 per mode.
REQ-009 aes_keyvalid  out  1  one-cycle start pulse to AES_TOP.
REQ-010 aes_outtxt  in  128  AES_TOP result bus.
REQ-011 aes_enc_finish / aes_dec_finish  in / in  1 / 1  AES_TOP completion flags, used on rising edge.
REQ-012 out_valid / out_ready / out_data  out / in / out  1 / 1 / 32  downstream result word stream.
REQ-013 out_last / out_is_dec  out / out  1 / 1  last word of a 4-word result; result is decryption output.
REQ-014 busy / err  out / out  1 / 1  transaction in progress; one-cycle timeout pulse.

Function
REQ-015 States: IDLE, LOAD_KEY, LOAD_TXT, START, WAIT, DRAIN.
REQ-016 Word transfer occurs only on in_valid && in_ready; in_ready = 1 in IDLE, LOAD_KEY, LOAD_TXT, else 0.
REQ-017 IDLE: on a transfer, latch cfg_mode (held for the whole transaction) and store word as key word 0; go to LOAD_KEY.
REQ-018 LOAD_KEY: accept key words 1..Nk-1 (Nk = 4/6/8), MSB-first into aes_key; after word Nk-1 go to LOAD_TXT.
REQ-019 LOAD_TXT: accept 4 text words into aes_intxt; after the 4th go to START.
REQ-020 START: aes_keyvalid = 1 for exactly one cycle; go to WAIT.
REQ-021 aes_key, aes_intxt, aes_nk, aes_nr stable from START until return to IDLE.
REQ-022 Finish detection: flag registered each cycle; event = flag high && registered flag low.
REQ-023 Enc event: capture aes_outtxt into enc buffer same cycle; dec event: capture into dec buffer; each buffer has a full bit.
REQ-024 Both events accepted in any state after START, including the same cycle and while DRAIN is sending enc words.
REQ-025 Output order: enc buffer 4 words (out_is_dec=0), then dec buffer 4 words (out_is_dec=1); word 0 = bits [0:31].
REQ-026 out_valid = 1 when the current buffer is full; out_data/out_last/out_is_dec held until out_ready; word index advances only on handshake.
REQ-027 out_last = 1 on word 3 of each buffer; on its handshake that buffer's full bit clears.
REQ-028 WAIT moves to DRAIN when the enc buffer is full; DRAIN returns to IDLE after dec word 3 handshakes.
REQ-029 Timeout counter clears on START and on each finish event; increments otherwise; reaching TIMEOUT before the pending event pulses err for one cycle, clears both buffers, and returns to IDLE.
REQ-030 busy = 1 in every state except IDLE.
REQ-031 Finish events in IDLE are ignored.

Reset
REQ-032 rst high at a clock edge: state IDLE; counters, buffers, full bits, aes_key, aes_intxt = 0; aes_nk = 4; aes_nr = 10; aes_keyvalid, out_valid, out_last, out_is_dec, err, busy = 0. Applies mid-transaction; the in-flight transaction is discarded.
REQ-033 First in_ready = 1 on the cycle after rst deasserts.

Verification
REQ-034 AES-128: mode 00, key 00010203..0c0d0e0f, text 00112233..ccddeeff; model returns ct 69c4e0d86a7b0430d8cdb78070b4c55a -> exactly one aes_keyvalid pulse, nk/nr 4/10, output 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a(last), then 00112233..ccddeeff with out_is_dec=1.
REQ-035 AES-192/256: key 00..17 / 00..1f, same text -> aes_key tail zero for 192, nk/nr 6/12 and 8/14, enc words dda97ca4.. / 8ea2b7ca.. emitted.
REQ-036 Back-pressure: out_ready toggled 1-0-0-1 and dec finish arriving during enc drain -> no word lost, duplicated or reordered; dec captured correctly.
REQ-037 Input gaps: in_valid low on random cycles during load -> aes_key/aes_intxt identical to gap-free case.
REQ-038 Timeout: TIMEOUT=16, model never raises enc finish -> err pulse 16 cycles after START, busy low, next transaction completes normally.
REQ-039 Reset mid-DRAIN after 2 enc words -> all outputs at reset values next cycle; new transaction completes normally.
